// File: rtl/nlp16_pkg.sv
// Shared definitions for the nlp16 front end (fetch and decode).
package nlp16_pkg;

    localparam int WORD_W  = 16;
    localparam int EXT_BIT = 15;

    typedef enum logic [1:0] {
        S_FETCH1,
        S_FETCH2,
        S_ISSUE
    } fetch_state_t;

    // An instruction carries an extension word when its top bit is set.
    function automatic logic is_two_word(input logic [WORD_W-1:0] ir);
        return ir[EXT_BIT];
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the pc, assembles 1/2-word instructions and holds them
// until the decoder accepts; execute-stage redirects override everything.
module instruction_fetch
    import nlp16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [WORD_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [WORD_W-1:0] i_mem_data,
    input  logic              i_mem_valid,
    output logic [WORD_W-1:0] o_ir1,
    output logic [WORD_W-1:0] o_ir2,
    output logic [WORD_W-1:0] o_pc,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_jump,
    input  logic [WORD_W-1:0] i_jump_addr
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir1_q, ir1_d;
    logic [WORD_W-1:0] ir2_q, ir2_d;
    logic [WORD_W-1:0] ipc_q, ipc_d;
    logic              started_q;
    logic              mem_rd;
    logic              xfer;

    // started_q keeps the read request low for the first cycle out of reset,
    // so every output stays a pure function of registers.
    assign mem_rd = started_q && (state_q != S_ISSUE);
    assign xfer   = mem_rd && i_mem_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir1_d   = ir1_q;
        ir2_d   = ir2_q;
        ipc_d   = ipc_q;
        if (i_jump) begin
            pc_d    = i_jump_addr;
            state_d = S_FETCH1;
        end else begin
            unique case (state_q)
                S_FETCH1: begin
                    if (xfer) begin
                        ir1_d = i_mem_data;
                        ipc_d = pc_q;
                        pc_d  = pc_q + 16'd1;
                        if (is_two_word(i_mem_data)) begin
                            state_d = S_FETCH2;
                        end else begin
                            ir2_d   = '0;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_FETCH2: begin
                    if (xfer) begin
                        ir2_d   = i_mem_data;
                        pc_d    = pc_q + 16'd1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_ready) state_d = S_FETCH1;
                end
                default: state_d = S_FETCH1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH1;
            pc_q      <= RESET_PC;
            ir1_q     <= '0;
            ir2_q     <= '0;
            ipc_q     <= RESET_PC;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir1_q     <= ir1_d;
            ir2_q     <= ir2_d;
            ipc_q     <= ipc_d;
            started_q <= 1'b1;
        end
    end

    assign o_mem_addr = pc_q;
    assign o_mem_rd   = mem_rd;
    assign o_ir1      = ir1_q;
    assign o_ir2      = ir2_q;
    assign o_pc       = ipc_q;
    assign o_valid    = (state_q == S_ISSUE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder, instruction scoreboard and
// directed scenarios; a second instance covers RESET_PC at the top of memory.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, ready, jump;
    logic [15:0] jump_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        rst_a, rst_b;

    logic [15:0] a_addr, a_ir1, a_ir2, a_pc, b_addr, b_ir1, b_ir2, b_pc;
    logic        a_rd, a_valid, b_rd, b_valid;
    logic [15:0] m_mem_addr, m_ir1, m_ir2, m_pc;
    logic        m_mem_rd, m_valid;

    // Only the selected instance runs; the other is held in reset.
    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;

    instruction_fetch #(.RESET_PC(16'h0000)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .o_mem_addr(a_addr), .o_mem_rd(a_rd),
        .i_mem_data(mem_data), .i_mem_valid(mem_valid), .o_ir1(a_ir1),
        .o_ir2(a_ir2), .o_pc(a_pc), .o_valid(a_valid), .i_ready(ready),
        .i_jump(jump), .i_jump_addr(jump_addr)
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .o_mem_addr(b_addr), .o_mem_rd(b_rd),
        .i_mem_data(mem_data), .i_mem_valid(mem_valid), .o_ir1(b_ir1),
        .o_ir2(b_ir2), .o_pc(b_pc), .o_valid(b_valid), .i_ready(ready),
        .i_jump(jump), .i_jump_addr(jump_addr)
    );

    assign m_mem_addr = sel ? b_addr  : a_addr;
    assign m_mem_rd   = sel ? b_rd    : a_rd;
    assign m_ir1      = sel ? b_ir1   : a_ir1;
    assign m_ir2      = sel ? b_ir2   : a_ir2;
    assign m_pc       = sel ? b_pc    : a_pc;
    assign m_valid    = sel ? b_valid : a_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    int          mem_wait = 0;

    typedef struct {
        logic [15:0] ir1;
        logic [15:0] ir2;
        logic [15:0] pc;
    } instr_t;
    instr_t exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {15'b0, act}, {15'b0, exp});
    endtask

    // Reference: the instruction at address a, read straight from memory.
    task automatic push_instr(input logic [15:0] a);
        instr_t      t;
        logic [15:0] a1;
        a1    = a + 16'd1;
        t.ir1 = mem[a];
        t.ir2 = t.ir1[15] ? mem[a1] : 16'h0000;
        t.pc  = a;
        exp_q.push_back(t);
    endtask

    task automatic wait_cond(input int kind, input logic [15:0] v, input string name);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            case (kind)
                0:       hit = m_valid && (m_pc == v);
                1:       hit = m_mem_rd && (m_mem_addr == v);
                default: hit = m_valid;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL timeout_%s: got no event in %0d cycles, expected %h", name, n, v);
        end
    endtask

    // Memory responder: answers after mem_wait idle cycles of a held request.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_valid = 1'b0;
        mem_data  = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            if (m_mem_rd) begin
                if (wcnt >= mem_wait) begin
                    mem_valid = 1'b1;
                    mem_data  = mem[m_mem_addr];
                    wcnt      = 0;
                end else begin
                    mem_valid = 1'b0;
                    mem_data  = 16'hDEAD;
                    wcnt++;
                end
            end else begin
                mem_valid = 1'b0;
                mem_data  = 16'hDEAD;
                wcnt      = 0;
            end
        end
    end

    // Scoreboard on every accepted instruction, plus stall stability.
    initial begin
        instr_t      t;
        logic        p_stall, p_sel;
        logic [15:0] p_ir1, p_ir2, p_pc;
        p_stall = 1'b0;
        p_sel   = 1'b0;
        p_ir1   = '0;
        p_ir2   = '0;
        p_pc    = '0;
        forever begin
            @(negedge clk);
            if (m_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_unexpected: got pc %h expected no instruction", m_pc);
                end else begin
                    t = exp_q.pop_front();
                    check("acc_ir1", m_ir1, t.ir1);
                    check("acc_ir2", m_ir2, t.ir2);
                    check("acc_pc", m_pc, t.pc);
                end
            end
            if (p_stall && (p_sel == sel)) begin
                chk1("stall_valid", m_valid, 1'b1);
                check("stall_ir1", m_ir1, p_ir1);
                check("stall_ir2", m_ir2, p_ir2);
                check("stall_pc", m_pc, p_pc);
            end
            p_stall = m_valid && !ready && !jump && !rst;
            p_sel   = sel;
            p_ir1   = m_ir1;
            p_ir2   = m_ir2;
            p_pc    = m_pc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int exp_rd   [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int exp_addr [14] = '{6, 6, 6, 6, 7, 7, 7, 7, 7, 8, 8, 8, 8, 9};

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0000; mem[16'h0001] = 16'h1111;
        mem[16'h0002] = 16'h2222; mem[16'h0003] = 16'h0033;
        mem[16'h0004] = 16'h8000; mem[16'h0005] = 16'h3000;
        mem[16'h0006] = 16'h0006; mem[16'h0007] = 16'h8007;
        mem[16'h0008] = 16'h0008; mem[16'h0009] = 16'h0009;
        mem[16'h000A] = 16'h800A; mem[16'h000B] = 16'h000B;
        mem[16'h0100] = 16'h0100; mem[16'h0101] = 16'h0101;
        mem[16'hFFFF] = 16'h8000;

        rst = 1'b1; sel = 1'b0; ready = 1'b1; jump = 1'b0; jump_addr = 16'h0;
        foreach (exp_q[i]) exp_q.delete(i);
        push_instr(16'h0000); push_instr(16'h0001); push_instr(16'h0002);
        push_instr(16'h0003); push_instr(16'h0004); push_instr(16'h0006);
        push_instr(16'h0007); push_instr(16'h0009); push_instr(16'h0100);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_rd", m_mem_rd, 1'b0);
        chk1("rst_valid", m_valid, 1'b0);
        check("rst_addr", m_mem_addr, 16'h0000);
        check("rst_ir1", m_ir1, 16'h0000);
        check("rst_ir2", m_ir2, 16'h0000);
        check("rst_pc", m_pc, 16'h0000);

        // Release; first request in the next cycle, zero-wait word 0.
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk1("r0_rd", m_mem_rd, 1'b0);
        @(negedge clk);
        chk1("r1_rd", m_mem_rd, 1'b1);
        check("r1_addr", m_mem_addr, 16'h0000);
        @(negedge clk);
        chk1("r2_valid", m_valid, 1'b1);
        check("r2_ir1", m_ir1, 16'h0000);
        check("r2_ir2", m_ir2, 16'h0000);
        check("r2_pc", m_pc, 16'h0000);
        @(negedge clk);
        chk1("r3_rd", m_mem_rd, 1'b1);
        check("r3_addr", m_mem_addr, 16'h0001);

        // Two-word at 4, stalled for three cycles.
        wait_cond(0, 16'h0004, "pc4");
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall4_valid", m_valid, 1'b1);
            check("stall4_ir1", m_ir1, 16'h8000);
            check("stall4_ir2", m_ir2, 16'h3000);
            check("stall4_pc", m_pc, 16'h0004);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        ready    = 1'b1;
        mem_wait = 3;

        // Three wait cycles per word: request held, address stable.
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk1("wait_rd", m_mem_rd, exp_rd[i] != 0);
            check("wait_addr", m_mem_addr, 16'(exp_addr[i]));
            chk1("wait_valid", m_valid, exp_rd[i] == 0);
        end
        mem_wait = 0;

        // Redirect in the cycle the extension word of A/B arrives.
        wait_cond(1, 16'h000B, "fetch2_b");
        jump      = 1'b1;
        jump_addr = 16'h0100;
        @(posedge clk); #1;
        jump = 1'b0;
        @(negedge clk);
        chk1("jmp_rd", m_mem_rd, 1'b1);
        check("jmp_addr", m_mem_addr, 16'h0100);
        chk1("jmp_valid", m_valid, 1'b0);

        // Reset while presenting 0x101 (never accepted).
        wait_cond(0, 16'h0101, "pc101");
        ready = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk1("pre_rst_valid", m_valid, 1'b1);
        @(negedge clk);
        chk1("issue_rst_valid", m_valid, 1'b0);
        chk1("issue_rst_rd", m_mem_rd, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("restart_rd", m_mem_rd, 1'b1);
        check("restart_addr", m_mem_addr, 16'h0000);

        // Instance with RESET_PC=FFFF: two-word instruction across the wrap.
        @(posedge clk); #1;
        sel = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("b_rst_pc", m_pc, 16'hFFFF);
        check("b_rst_addr", m_mem_addr, 16'hFFFF);
        chk1("b_rst_rd", m_mem_rd, 1'b0);
        chk1("b_rst_valid", m_valid, 1'b0);
        mem[16'h0000] = 16'h1234;
        push_instr(16'hFFFF);
        ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_cond(2, 16'hFFFF, "wrap_valid");
        @(negedge clk);
        check("wrap_ir1", m_ir1, 16'h8000);
        check("wrap_ir2", m_ir2, 16'h1234);
        check("wrap_pc", m_pc, 16'hFFFF);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk1("wrap_next_rd", m_mem_rd, 1'b1);
        check("wrap_next_addr", m_mem_addr, 16'h0001);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_leftover", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch unit that reads 16-bit instruction words from the instruction memory port and presents complete instructions to `instruction_decoder` as the `ir1`/`ir2` pair. It owns the program counter and assembles one- or two-word instructions. It holds each instruction until the decoder accepts it. It also handles branch redirects from the execute stage.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, word address of the first fetch after reset.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `o_mem_addr`  out  16  word address of the current read.
- `o_mem_rd`  out  1  read request.
- `i_mem_data`  in  16  read data; valid only in a cycle with `i_mem_valid`.
- `i_mem_valid`  in  1  read completes this cycle.
- `o_ir1`  out  16  first instruction word, to decoder `i_ir1`.
- `o_ir2`  out  16  extension word, to decoder `i_ir2`; 16'h0000 for one-word instructions.
- `o_pc`  out  16  address of `o_ir1` of the presented instruction.
- `o_valid`  out  1  `o_ir1`/`o_ir2`/`o_pc` hold a complete instruction.
- `i_ready`  in  1  decoder accepts the instruction when `o_valid && i_ready`.
- `i_jump`  in  1  redirect request.
- `i_jump_addr`  in  16  redirect target.

## Operation
- Two-word rule: an instruction has an extension word when `ir1[15]` is 1; otherwise it is one word.
- States:
  - `S_FETCH1`: `o_mem_rd`=1, `o_mem_addr`=pc. On `i_mem_valid`, capture `ir1` into the `o_ir1` register, set `o_pc`=pc, and increment pc. If `i_mem_data[15]`=1, go to `S_FETCH2`; otherwise set `o_ir2`=0 and go to `S_ISSUE`.
  - `S_FETCH2`: `o_mem_rd`=1, `o_mem_addr`=pc. On `i_mem_valid`, capture `o_ir2`, increment pc, and go to `S_ISSUE`.
  - `S_ISSUE`: `o_valid`=1 and `o_mem_rd`=0. Outputs stay stable while `!i_ready`. When `i_ready` is high, go to `S_FETCH1`.
- Memory port: the request is held (`o_mem_rd`=1, address stable) until `i_mem_valid`. A transfer occurs only in a cycle with `o_mem_rd && i_mem_valid`. `i_mem_valid` while `o_mem_rd`=0 is ignored.
- PC arithmetic: 16-bit and unsigned. 16'hFFFF+1 wraps to 16'h0000. A two-word instruction may straddle the wrap.
- Redirect:
  - `i_jump` in any state sets pc to `i_jump_addr` and the next state to `S_FETCH1`. `o_valid` drops the next cycle.
  - Redirect during `S_FETCH1`/`S_FETCH2`: a same-cycle `i_mem_valid` word is discarded, and a partial instruction is dropped.
  - Redirect during `S_ISSUE` with `i_ready`=1: the instruction counts as accepted. With `i_ready`=0 it is discarded.
  - `i_jump` has priority over every other event.
- `i_rst` has priority over `i_jump` and memory events. Asserting `i_rst` mid-fetch abandons the request. The memory must tolerate the request being dropped.

## Timing
- Reset values: `o_mem_rd`=0, `o_mem_addr`=`RESET_PC`, `o_ir1`=0, `o_ir2`=0, `o_pc`=`RESET_PC`, `o_valid`=0, state=`S_FETCH1`, pc=`RESET_PC`.
- First request: `o_mem_rd` rises in the first cycle after `i_rst` deasserts.
- Zero-wait memory with `i_ready`=1:
  - A one-word instruction is fetched in cycle N and presented in N+1, with the next fetch in N+2. Throughput is 1 instruction per 2 cycles.
  - A two-word instruction is presented in N+2, giving 1 instruction per 3 cycles.
- Each memory wait cycle adds one cycle.
- Redirect: `i_jump` asserted in cycle N produces `o_mem_addr`=`i_jump_addr` with `o_mem_rd`=1 in cycle N+1.
- All outputs are registered or decoded from state only. There is no combinational path from `i_ready`, `i_jump` or `i_mem_*` to any output.

## Structure
- Shared package `nlp16_pkg`:
  - `fetch_state_t` enum (`S_FETCH1`, `S_FETCH2`, `S_ISSUE`).
  - `EXT_BIT`=15.
  - `function is_two_word(logic [15:0] ir)`, also used by `instruction_decoder`.
  - `WORD_W`=16.
- Single module with no sub-module; the pc register and output registers are inline.

## Test plan
- Reset, then memory returns 16'h0000 at addr 0 with zero wait: `o_valid` in the 2nd cycle after reset release, `o_ir1`=16'h0000, `o_ir2`=16'h0000, `o_pc`=0. The next `o_mem_addr` is 1.
- Two-word: mem[4]=16'h8000, mem[5]=16'h3000, with `i_ready` held 0 for 3 cycles. Required: `o_ir1`=16'h8000, `o_ir2`=16'h3000, `o_pc`=4, all stable while stalled. The next fetch is at 6.
- Memory wait of 3 cycles on each word: `o_mem_addr` is stable and `o_mem_rd` stays high throughout, and the instruction is presented exactly once.
- `i_jump`=1 with `i_jump_addr`=16'h0100 in the same cycle as `i_mem_valid` in `S_FETCH2`: the word is discarded, the next `o_mem_addr`=16'h0100, and no `o_valid` occurs for the dropped instruction.
- Wrap: `RESET_PC`=16'hFFFF, mem[FFFF]=16'h8000, mem[0000]=16'h1234. Required: `o_ir2`=16'h1234 and `o_pc`=16'hFFFF, with the next fetch at 1.
- `i_rst` asserted while in `S_ISSUE`: the next cycle has `o_valid`=0 and `o_mem_rd`=0. After release, fetching restarts at `RESET_PC`.
